// File: rtl/video_fetch_arbiter.sv
// video_fetch_arbiter
//   Shares one banked SRAM port set between a peripheral bus slave and a
//   video prefetch engine. The video engine streams words from a wrapping
//   read pointer into a small FIFO. The bus slave serves reads and writes
//   that fall inside its address window.
//
//   Optional feature macro: VIDEO_UNDERRUN_DETECT_EN
//     When defined, a pop while the FIFO is empty sets a sticky video_underrun
//     flag. When undefined, video_underrun is tied to 0.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   peripheralBus_*         bus slave: we/oe strobes, byte address, byte
//                           select, write data, busy, read data, read valid
//                           (requestOutput)
//   video_enable/start      fetch enable; start pulse that flushes the FIFO
//                           and loads video_startAddress
//   video_pop/data/valid    FIFO consumer side
//   video_underrun          sticky pop-while-empty flag
//   sram_*                  shared SRAM port; one active-low csb per bank;
//                           sram_dout carries bank b at bits 32b+31:32b
module video_fetch_arbiter #(
  parameter int          BANKS             = 2,
  parameter int          SRAM_ADDRESS_SIZE = 9,
  parameter int          FIFO_DEPTH        = 4,
  parameter logic [23:0] BASE_ADDRESS      = 24'h000000,
  localparam int         AW                = SRAM_ADDRESS_SIZE + $clog2(BANKS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         peripheralBus_we,
  input  logic                         peripheralBus_oe,
  input  logic [23:0]                  peripheralBus_address,
  input  logic [3:0]                   peripheralBus_byteSelect,
  input  logic [31:0]                  peripheralBus_dataWrite,
  output logic                         peripheralBus_busy,
  output logic [31:0]                  peripheralBus_dataRead,
  output logic                         requestOutput,
  input  logic                         video_enable,
  input  logic                         video_start,
  input  logic [AW-1:0]                video_startAddress,
  input  logic                         video_pop,
  output logic [31:0]                  video_data,
  output logic                         video_valid,
  output logic                         video_underrun,
  output logic [BANKS-1:0]             sram_csb,
  output logic                         sram_web,
  output logic [3:0]                   sram_wmask,
  output logic [SRAM_ADDRESS_SIZE-1:0] sram_addr,
  output logic [31:0]                  sram_din,
  input  logic [32*BANKS-1:0]          sram_dout
);
  localparam int          BW        = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [24:0] WIN_BYTES = 25'(4 * BANKS * (2 ** SRAM_ADDRESS_SIZE));
  localparam logic [24:0] WIN_END   = {1'b0, BASE_ADDRESS} + WIN_BYTES;

  logic [BANKS-1:0][31:0] w_dout;
  assign w_dout = sram_dout;

  // State
  logic [AW-1:0] r_vptr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wr, r_rd;
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [31:0]   r_last;
  logic          r_rd_vid, r_rd_bus;
  logic [BW-1:0] r_rd_bank;

  // Bus decode (window-relative word address)
  logic                         w_in_win, w_bus_req, w_bus_wr;
  logic [AW-1:0]                w_bus_word;
  logic [BW-1:0]                w_bus_bank, w_vid_bank;
  logic [SRAM_ADDRESS_SIZE-1:0] w_bus_row, w_vid_row;

  assign w_in_win   = (peripheralBus_we | peripheralBus_oe) &&
                      (peripheralBus_address >= BASE_ADDRESS) &&
                      ({1'b0, peripheralBus_address} < WIN_END);
  assign w_bus_word = AW'((peripheralBus_address - BASE_ADDRESS) >> 2);
  assign w_bus_bank = BW'(w_bus_word >> SRAM_ADDRESS_SIZE);
  assign w_bus_row  = w_bus_word[SRAM_ADDRESS_SIZE-1:0];
  assign w_vid_bank = BW'(r_vptr >> SRAM_ADDRESS_SIZE);
  assign w_vid_row  = r_vptr[SRAM_ADDRESS_SIZE-1:0];
  assign w_bus_wr   = peripheralBus_we;
  // The master keeps oe high during the data-return cycle; that cycle is
  // the completion, not a new request.
  assign w_bus_req  = w_in_win & ~r_rd_bus;

  // Arbitration. Only one access is ever in flight, so only the video
  // read in flight counts against FIFO space.
  logic [CW-1:0] w_fill;
  logic          w_vid_want, w_vid_gnt, w_bus_gnt;

  assign w_fill     = r_count + CW'(r_rd_vid);
  assign w_vid_want = video_enable & ~video_start & (w_fill < CW'(FIFO_DEPTH));
  assign w_vid_gnt  = w_vid_want & (~w_bus_req | (r_count <= CW'(FIFO_DEPTH / 2)));
  assign w_bus_gnt  = w_bus_req & ~w_vid_gnt;

  // SRAM port and bus handshake; rst_n gates everything so reset takes
  // effect mid-cycle rather than at the next edge.
  always_comb begin
    sram_csb   = '1;
    sram_web   = 1'b1;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_din   = '0;
    if (rst_n && w_vid_gnt) begin
      sram_csb[w_vid_bank] = 1'b0;
      sram_addr            = w_vid_row;
    end else if (rst_n && w_bus_gnt) begin
      sram_csb[w_bus_bank] = 1'b0;
      sram_addr            = w_bus_row;
      if (w_bus_wr) begin
        sram_web   = 1'b0;
        sram_wmask = peripheralBus_byteSelect;
        sram_din   = peripheralBus_dataWrite;
      end
    end
  end

  assign peripheralBus_busy     = rst_n & w_bus_req & ~(w_bus_gnt & w_bus_wr);
  assign requestOutput          = r_rd_bus;
  assign peripheralBus_dataRead = r_rd_bus ? w_dout[r_rd_bank] : '0;

  // FIFO. A start flush wins over a same-cycle push or pop.
  logic w_push, w_pop;
  assign w_push      = r_rd_vid & ~video_start;
  assign w_pop       = video_pop & (r_count != '0) & ~video_start;
  assign video_valid = (r_count != '0);
  assign video_data  = video_valid ? r_mem[r_rd] : r_last;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_dout[r_rd_bank];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vptr    <= '0;
      r_count   <= '0;
      r_wr      <= '0;
      r_rd      <= '0;
      r_last    <= '0;
      r_rd_vid  <= 1'b0;
      r_rd_bus  <= 1'b0;
      r_rd_bank <= '0;
    end else begin
      r_rd_vid <= w_vid_gnt;
      r_rd_bus <= w_bus_gnt & ~w_bus_wr;
      if (w_vid_gnt)      r_rd_bank <= w_vid_bank;
      else if (w_bus_gnt) r_rd_bank <= w_bus_bank;
      if (video_start) begin
        r_vptr  <= video_startAddress;
        r_count <= '0;
        r_wr    <= '0;
        r_rd    <= '0;
      end else begin
        if (w_vid_gnt) r_vptr <= r_vptr + 1'b1;
        if (w_push) r_wr <= r_wr + 1'b1;
        if (w_pop) begin
          r_last <= r_mem[r_rd];
          r_rd   <= r_rd + 1'b1;
        end
        if (w_push && !w_pop)      r_count <= r_count + 1'b1;
        else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
    end
  end

`ifdef VIDEO_UNDERRUN_DETECT_EN
  logic r_underrun;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_underrun <= 1'b0;
    else if (video_start)                  r_underrun <= 1'b0;
    else if (video_pop && r_count == '0)   r_underrun <= 1'b1;
  end
  assign video_underrun = r_underrun;
`else
  assign video_underrun = 1'b0;
`endif

endmodule

// File: tb/tb_video_fetch_arbiter.sv
module tb_video_fetch_arbiter;
  localparam int BANKS = 2;
  localparam int SAS   = 9;
  localparam int DEPTH = 4;
  localparam int AW    = 10;
  localparam int NW    = 1024;
`ifdef VIDEO_UNDERRUN_DETECT_EN
  localparam logic UR_EXP = 1'b1;
`else
  localparam logic UR_EXP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              peripheralBus_we, peripheralBus_oe;
  logic [23:0]       peripheralBus_address;
  logic [3:0]        peripheralBus_byteSelect;
  logic [31:0]       peripheralBus_dataWrite;
  logic              peripheralBus_busy;
  logic [31:0]       peripheralBus_dataRead;
  logic              requestOutput;
  logic              video_enable, video_start, video_pop;
  logic [AW-1:0]     video_startAddress;
  logic [31:0]       video_data;
  logic              video_valid, video_underrun;
  logic [BANKS-1:0]  sram_csb;
  logic              sram_web;
  logic [3:0]        sram_wmask;
  logic [SAS-1:0]    sram_addr;
  logic [31:0]       sram_din;
  logic [32*BANKS-1:0] sram_dout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  video_fetch_arbiter #(.BANKS(BANKS), .SRAM_ADDRESS_SIZE(SAS), .FIFO_DEPTH(DEPTH),
                        .BASE_ADDRESS(24'h000000)) dut (
    .clk(clk), .rst_n(rst_n),
    .peripheralBus_we(peripheralBus_we), .peripheralBus_oe(peripheralBus_oe),
    .peripheralBus_address(peripheralBus_address),
    .peripheralBus_byteSelect(peripheralBus_byteSelect),
    .peripheralBus_dataWrite(peripheralBus_dataWrite),
    .peripheralBus_busy(peripheralBus_busy),
    .peripheralBus_dataRead(peripheralBus_dataRead),
    .requestOutput(requestOutput),
    .video_enable(video_enable), .video_start(video_start),
    .video_startAddress(video_startAddress),
    .video_pop(video_pop), .video_data(video_data), .video_valid(video_valid),
    .video_underrun(video_underrun),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // Banked SRAM: one-cycle read latency, byte-masked writes. Word w lives in
  // bank w/512, row w%512.
  logic [31:0]            smem [NW];
  logic [BANKS-1:0][31:0] tb_dout;
  assign sram_dout = tb_dout;

  always @(posedge clk) begin
    for (int b = 0; b < BANKS; b++) begin
      if (!sram_csb[b]) begin
        if (!sram_web) begin
          for (int k = 0; k < 4; k++)
            if (sram_wmask[k]) smem[b*512 + int'(sram_addr)][8*k +: 8] <= sram_din[8*k +: 8];
        end else begin
          tb_dout[b] <= smem[b*512 + int'(sram_addr)];
        end
      end
    end
  end

  // Reference image of memory, updated by the bench when it writes.
  logic [31:0] ref_mem [NW];

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [1:0] csb_of(input int w);
    logic [1:0] c;
    c = 2'b11;
    c[w / 512] = 1'b0;
    return c;
  endfunction

  initial begin
    for (int i = 0; i < NW; i++) begin
      smem[i]    <= init_word(i);
      ref_mem[i]  = init_word(i);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    n_checks++; if (sram_csb !== 2'b11) begin n_fail++; $display("FAIL rst_csb got=%b exp=11", sram_csb); end
    n_checks++; if ({sram_web, sram_wmask} !== 5'b10000) begin n_fail++; $display("FAIL rst_web_wmask got=%b exp=10000", {sram_web, sram_wmask}); end
    n_checks++; if ({peripheralBus_busy, requestOutput} !== 2'b00) begin n_fail++; $display("FAIL rst_busy_req got=%b exp=00", {peripheralBus_busy, requestOutput}); end
    n_checks++; if (peripheralBus_dataRead !== 32'h0) begin n_fail++; $display("FAIL rst_dataRead got=%h exp=0", peripheralBus_dataRead); end
    n_checks++; if ({video_valid, video_underrun} !== 2'b00) begin n_fail++; $display("FAIL rst_valid_ur got=%b exp=00", {video_valid, video_underrun}); end
    n_checks++; if (video_data !== 32'h0) begin n_fail++; $display("FAIL rst_vdata got=%h exp=0", video_data); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic bus_write(input int w, input logic [3:0] bs, input logic [31:0] d);
    @(negedge clk);
    peripheralBus_we = 1'b1; peripheralBus_address = 24'(w * 4);
    peripheralBus_byteSelect = bs; peripheralBus_dataWrite = d;
    #1;
    n_checks++; if (sram_csb !== csb_of(w)) begin n_fail++; $display("FAIL wr_csb w=%0d got=%b exp=%b", w, sram_csb, csb_of(w)); end
    n_checks++; if (sram_addr !== 9'(w % 512)) begin n_fail++; $display("FAIL wr_row w=%0d got=%0d exp=%0d", w, sram_addr, w % 512); end
    n_checks++; if ({sram_web, sram_wmask} !== {1'b0, bs}) begin n_fail++; $display("FAIL wr_web_mask got=%b exp=%b", {sram_web, sram_wmask}, {1'b0, bs}); end
    n_checks++; if (sram_din !== d) begin n_fail++; $display("FAIL wr_din got=%h exp=%h", sram_din, d); end
    n_checks++; if (peripheralBus_busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy got=%b exp=0", peripheralBus_busy); end
    for (int k = 0; k < 4; k++) if (bs[k]) ref_mem[w][8*k +: 8] = d[8*k +: 8];
    @(negedge clk); peripheralBus_we = 1'b0;
  endtask

  task automatic test_bus_write;
    bus_write(513, 4'hF, 32'hDEADBEEF);
    bus_write(2, 4'b0101, 32'h11223344);
  endtask

  task automatic bus_read(input int w);
    @(negedge clk);
    peripheralBus_oe = 1'b1; peripheralBus_address = 24'(w * 4);
    #1;
    n_checks++; if (peripheralBus_busy !== 1'b1) begin n_fail++; $display("FAIL rd_grant_busy got=%b exp=1", peripheralBus_busy); end
    n_checks++; if ({sram_csb, sram_web} !== {csb_of(w), 1'b1}) begin n_fail++; $display("FAIL rd_grant_csb got=%b exp=%b", {sram_csb, sram_web}, {csb_of(w), 1'b1}); end
    @(negedge clk); #1;
    n_checks++; if ({peripheralBus_busy, requestOutput} !== 2'b01) begin n_fail++; $display("FAIL rd_resp_flags got=%b exp=01", {peripheralBus_busy, requestOutput}); end
    n_checks++; if (peripheralBus_dataRead !== ref_mem[w]) begin n_fail++; $display("FAIL rd_data w=%0d got=%h exp=%h", w, peripheralBus_dataRead, ref_mem[w]); end
    n_checks++; if (sram_csb !== 2'b11) begin n_fail++; $display("FAIL rd_no_reissue got=%b exp=11", sram_csb); end
    peripheralBus_oe = 1'b0;
    @(negedge clk); #1;
    n_checks++; if ({requestOutput, peripheralBus_dataRead} !== 33'h0) begin n_fail++; $display("FAIL rd_after got=%h exp=0", {requestOutput, peripheralBus_dataRead}); end
  endtask

  task automatic test_bus_read;
    bus_read(513);
    bus_read(2);
  endtask

  task automatic test_out_of_window;
    @(negedge clk);
    peripheralBus_oe = 1'b1; peripheralBus_address = 24'h001000;
    #1;
    n_checks++; if ({peripheralBus_busy, sram_csb} !== 3'b011) begin n_fail++; $display("FAIL oow_busy_csb got=%b exp=011", {peripheralBus_busy, sram_csb}); end
    @(negedge clk); peripheralBus_we = 1'b1; peripheralBus_oe = 1'b0; peripheralBus_address = 24'hFFFFFC;
    #1;
    n_checks++; if ({requestOutput, peripheralBus_busy, sram_csb, sram_web} !== 5'b00111) begin n_fail++; $display("FAIL oow_write got=%b exp=00111", {requestOutput, peripheralBus_busy, sram_csb, sram_web}); end
    @(negedge clk); peripheralBus_we = 1'b0;
  endtask

  task automatic test_video_wrap;
    int fetched[$];
    @(negedge clk);
    video_start = 1'b1; video_startAddress = 10'd1022; video_enable = 1'b1;
    #1;
    n_checks++; if (sram_csb !== 2'b11) begin n_fail++; $display("FAIL vw_start_idle got=%b exp=11", sram_csb); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); video_start = 1'b0;
      #1;
      if (sram_csb !== 2'b11) fetched.push_back(((sram_csb == 2'b01) ? 512 : 0) + int'(sram_addr));
    end
    n_checks++; if (fetched.size() != 4) begin n_fail++; $display("FAIL vw_fetch_count got=%0d exp=4", fetched.size()); end
    for (int i = 0; i < fetched.size() && i < 4; i++) begin
      n_checks++; if (fetched[i] != (1022 + i) % NW) begin n_fail++; $display("FAIL vw_fetch_addr i=%0d got=%0d exp=%0d", i, fetched[i], (1022 + i) % NW); end
    end
    @(negedge clk); video_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); video_pop = 1'b1;
      #1;
      n_checks++; if ({video_valid, video_data} !== {1'b1, ref_mem[(1022 + i) % NW]}) begin n_fail++; $display("FAIL vw_pop i=%0d got=%h exp=%h", i, {video_valid, video_data}, {1'b1, ref_mem[(1022 + i) % NW]}); end
    end
    @(negedge clk); video_pop = 1'b0;
    #1;
    n_checks++; if ({video_valid, video_data} !== {1'b0, ref_mem[1]}) begin n_fail++; $display("FAIL vw_empty_hold got=%h exp=%h", {video_valid, video_data}, {1'b0, ref_mem[1]}); end
  endtask

  task automatic test_arbitration;
    logic [1:0] exp_csb [4];
    int         exp_row [4];
    // Video words 601..603 in bank 1, then bus word 4 in bank 0.
    exp_csb = '{2'b01, 2'b01, 2'b01, 2'b10};
    exp_row = '{89, 90, 91, 4};
    @(negedge clk); video_start = 1'b1; video_startAddress = 10'd600;
    @(negedge clk); video_start = 1'b0; video_enable = 1'b1;
    #1;
    n_checks++; if ({sram_csb, sram_addr} !== {2'b01, 9'd88}) begin n_fail++; $display("FAIL arb_first got=%b exp=%b", {sram_csb, sram_addr}, {2'b01, 9'd88}); end
    @(negedge clk); video_enable = 1'b0;
    @(negedge clk); video_enable = 1'b1; peripheralBus_oe = 1'b1; peripheralBus_address = 24'h000010;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_checks++; if (peripheralBus_busy !== 1'b1) begin n_fail++; $display("FAIL arb_busy i=%0d got=%b exp=1", i, peripheralBus_busy); end
      n_checks++; if ({sram_csb, sram_addr} !== {exp_csb[i], 9'(exp_row[i])}) begin n_fail++; $display("FAIL arb_grant i=%0d got=%b exp=%b", i, {sram_csb, sram_addr}, {exp_csb[i], 9'(exp_row[i])}); end
    end
    @(negedge clk); #1;
    n_checks++; if ({peripheralBus_busy, requestOutput, peripheralBus_dataRead} !== {2'b01, ref_mem[4]}) begin n_fail++; $display("FAIL arb_resp got=%h exp=%h", {peripheralBus_busy, requestOutput, peripheralBus_dataRead}, {2'b01, ref_mem[4]}); end
    peripheralBus_oe = 1'b0; video_enable = 1'b0;
  endtask

  task automatic test_underrun;
    @(negedge clk); video_start = 1'b1; video_startAddress = '0;
    @(negedge clk); video_start = 1'b0; video_pop = 1'b1;
    #1;
    n_checks++; if ({video_valid, video_data} !== {1'b0, ref_mem[1]}) begin n_fail++; $display("FAIL ur_flush got=%h exp=%h", {video_valid, video_data}, {1'b0, ref_mem[1]}); end
    @(negedge clk); video_pop = 1'b0;
    #1;
    n_checks++; if (video_underrun !== UR_EXP) begin n_fail++; $display("FAIL ur_set got=%b exp=%b", video_underrun, UR_EXP); end
    n_checks++; if (video_data !== ref_mem[1]) begin n_fail++; $display("FAIL ur_hold got=%h exp=%h", video_data, ref_mem[1]); end
    @(negedge clk); video_start = 1'b1;
    @(negedge clk); video_start = 1'b0;
    #1;
    n_checks++; if (video_underrun !== 1'b0) begin n_fail++; $display("FAIL ur_clear got=%b exp=0", video_underrun); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk); peripheralBus_oe = 1'b1; peripheralBus_address = 24'h000804;
    #1;
    n_checks++; if ({peripheralBus_busy, sram_csb} !== 3'b101) begin n_fail++; $display("FAIL rm_grant got=%b exp=101", {peripheralBus_busy, sram_csb}); end
    #1; rst_n = 1'b0;
    #1;
    n_checks++; if ({peripheralBus_busy, requestOutput, sram_csb, sram_web} !== 5'b00111) begin n_fail++; $display("FAIL rm_outputs got=%b exp=00111", {peripheralBus_busy, requestOutput, sram_csb, sram_web}); end
    n_checks++; if (peripheralBus_dataRead !== 32'h0) begin n_fail++; $display("FAIL rm_data got=%h exp=0", peripheralBus_dataRead); end
    @(negedge clk); rst_n = 1'b1; peripheralBus_oe = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if ({requestOutput, video_data} !== 33'h0) begin n_fail++; $display("FAIL rm_after i=%0d got=%h exp=0", i, {requestOutput, video_data}); end
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    int exp_ptr, rd_w, wait_cnt, start_w;
    bit rd_pend;
    start_w = int'($urandom_range(0, NW - 1));
    @(negedge clk); video_start = 1'b1; video_startAddress = AW'(start_w); video_enable = 1'b1;
    exp_ptr = start_w; rd_pend = 1'b0; rd_w = 0; wait_cnt = 0;
    @(negedge clk); video_start = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (!rd_pend && $urandom_range(0, 3) == 0) begin
        rd_pend = 1'b1; wait_cnt = 0;
        rd_w = int'($urandom_range(0, NW - 1));
        peripheralBus_oe = 1'b1; peripheralBus_address = 24'(rd_w * 4);
      end
      video_pop    = ($urandom_range(0, 1) == 1);
      video_enable = ($urandom_range(0, 7) != 0);
      #1;
      n_checks++; if (sram_web !== 1'b1) begin n_fail++; $display("FAIL rnd_no_write cyc=%0d got=%b exp=1", cyc, sram_web); end
      if (video_pop && video_valid) begin
        n_checks++; if (video_data !== ref_mem[exp_ptr]) begin n_fail++; $display("FAIL rnd_video cyc=%0d ptr=%0d got=%h exp=%h", cyc, exp_ptr, video_data, ref_mem[exp_ptr]); end
        exp_ptr = (exp_ptr + 1) % NW;
      end
      if (rd_pend) begin
        if (requestOutput) begin
          n_checks++; if ({peripheralBus_busy, peripheralBus_dataRead} !== {1'b0, ref_mem[rd_w]}) begin n_fail++; $display("FAIL rnd_bus cyc=%0d w=%0d got=%h exp=%h", cyc, rd_w, {peripheralBus_busy, peripheralBus_dataRead}, {1'b0, ref_mem[rd_w]}); end
          rd_pend = 1'b0; peripheralBus_oe = 1'b0;
        end else begin
          n_checks++; if (peripheralBus_busy !== 1'b1) begin n_fail++; $display("FAIL rnd_busy cyc=%0d got=%b exp=1", cyc, peripheralBus_busy); end
          wait_cnt++;
          if (wait_cnt > 32) begin
            n_fail++; $display("FAIL rnd_bus_timeout cyc=%0d w=%0d waited=%0d", cyc, rd_w, wait_cnt);
            rd_pend = 1'b0; peripheralBus_oe = 1'b0;
          end
        end
      end
    end
    @(negedge clk); video_pop = 1'b0; video_enable = 1'b0; peripheralBus_oe = 1'b0;
  endtask

  initial begin
    peripheralBus_we = 1'b0; peripheralBus_oe = 1'b0; peripheralBus_address = '0;
    peripheralBus_byteSelect = '0; peripheralBus_dataWrite = '0;
    video_enable = 1'b0; video_start = 1'b0; video_startAddress = '0; video_pop = 1'b0;
    test_reset();
    test_bus_write();
    test_bus_read();
    test_out_of_window();
    test_video_wrap();
    test_arbitration();
    test_underrun();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
